sseg_score_decoder: RTL
=======================

# sseg_score_decoder

Decodes the scoreboard's two 7-segment digit outputs back into a packed BCD score and a binary score. It filters glitches with a stability counter, flags illegal segment patterns, and reports each new stable score through a valid/ready handshake. It sits downstream of the scoreboard display path, as a self-check monitor on the board or as a synthesizable bench checker.

## Interface
Parameters:
- STABLE_CYCLES, 4, number of consecutive identical samples before a digit pair counts as stable; legal range 1..255.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sseg_hi  in  7  tens-digit segments, bit order {g,f,e,d,c,b,a}, active-high.
- sseg_low  in  7  units-digit segments, same encoding as sseg_hi.
- score_bcd  out  8  packed BCD score, {tens, units}.
- score_bin  out  7  binary score, 0..99.
- score_valid  out  1  a new score is held on score_bcd/score_bin.
- score_ready  in  1  consumer accepts the score on an edge where score_valid && score_ready.
- illegal  out  1  the current stable pair contains an undecodable digit.
- illegal_count  out  8  saturating count of illegal stable episodes.

## Operation
- Digit decode, combinational, per digit:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7C or 0x7D→6, 0x07→7, 0x7F→8, 0x67 or 0x6F→9.
  - Any other code is illegal.
- Input sample register s captures {sseg_hi, sseg_low} on every edge.
- Stability counter cnt, 8 bits:
  - Cleared to 0 when the new sample differs from s.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
  - The pair is stable when cnt == STABLE_CYCLES-1.
- FSM:
  - SETTLE → STABLE_OK when the pair is stable and both digits are legal.
  - SETTLE → STABLE_BAD when the pair is stable and either digit is illegal.
  - STABLE_OK or STABLE_BAD → SETTLE on any sample change.
- Event load happens when all of these hold: state is STABLE_OK, decoded value differs from last_reported (or no value has been reported since reset), and score_valid is low. The load then:
  - sets score_bcd and score_bin;
  - sets score_valid;
  - updates last_reported.
- Latest-value semantics: values that stabilize while score_valid is pending are never queued. Only the value current after acceptance is reported.
- Data and score_valid hold steady until accepted.
- score_bin = tens*10 + units, computed from the decoded digits and registered with score_bcd.
- illegal mirrors state == STABLE_BAD.
- illegal_count increments once on each SETTLE→STABLE_BAD transition and saturates at 255.

## Timing
- Reset values: score_bcd 0x00, score_bin 0, score_valid 0, illegal 0, illegal_count 0, cnt 0, state SETTLE, last_reported = none.
- Reset mid-operation discards any pending event. The first stable legal value after reset is always reported, including 00.
- Latency: a pair applied before edge 1 and held is sampled into s at edge 1. score_valid rises at edge STABLE_CYCLES, or STABLE_CYCLES+1 for STABLE_CYCLES=1. score_bcd updates on the same edge.
- A pair that changes at least once every STABLE_CYCLES edges never reports.
- Handshake:
  - Acceptance on an edge with score_valid && score_ready clears score_valid.
  - A new load can occur no earlier than the next edge, so there is a one-cycle bubble minimum between events.
- score_ready high with score_valid low has no effect.
- Return to a previously reported value after an intermediate unreported value: no event, because last_reported is unchanged.
- illegal rises on the same edge that a legal pair would have raised score_valid. It falls on the edge after the sample changes.

## Structure
- Shared package scoreboard_pkg:
  - typedefs sseg_t (logic [6:0]) and bcd_t (logic [3:0]);
  - localparams for the 12 accepted segment codes;
  - FSM state enum dec_state_e.
- Sub-module sseg_digit_decode: combinational, instantiated twice. Input sseg_t; outputs bcd_t digit and a legal bit.
- Top holds the sample register, counter, FSM, handshake and illegal counter.

## Test plan
- Reset low 20 cycles, then 0x3F/0x3F held → score_valid after STABLE_CYCLES edges with score_bcd 0x00, score_bin 0. Ready high → valid clears next edge.
- Drive "4","2" (0x66/0x5B), ready low for 50 cycles → score_bcd 0x42, score_bin 42 held stable with valid high throughout. Change the inputs to "4","3" while pending → 0x42 unchanged. After acceptance, the next event is 0x43.
- Alternate 6/9 codes 0x7C/0x6F → 0x69, score_bin 69. Then 0x7D/0x67 → no event, since the value equals last_reported.
- Toggle sseg_low every STABLE_CYCLES-1 cycles for 100 cycles → no event; illegal stays 0.
- Hold 0x00/0x3F → illegal high after the stable latency, illegal_count=1, no score event. Repeat 300 illegal episodes → count saturates at 255.
- Assert reset while score_valid is pending with 0x99 → all outputs zero. After release with 0x99 still driven → fresh event 0x99.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the 7-segment score decoder.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package scoreboard_pkg;

  typedef logic [6:0] sseg_t;
  typedef logic [3:0] bcd_t;

  localparam sseg_t SEG_0  = 7'h3F;
  localparam sseg_t SEG_1  = 7'h06;
  localparam sseg_t SEG_2  = 7'h5B;
  localparam sseg_t SEG_3  = 7'h4F;
  localparam sseg_t SEG_4  = 7'h66;
  localparam sseg_t SEG_5  = 7'h6D;
  localparam sseg_t SEG_6A = 7'h7C;
  localparam sseg_t SEG_6B = 7'h7D;
  localparam sseg_t SEG_7  = 7'h07;
  localparam sseg_t SEG_8  = 7'h7F;
  localparam sseg_t SEG_9A = 7'h67;
  localparam sseg_t SEG_9B = 7'h6F;

  typedef enum logic [1:0] {
    SETTLE     = 2'd0,
    STABLE_OK  = 2'd1,
    STABLE_BAD = 2'd2
  } dec_state_e;

  // Two BCD digits to binary, 0..99.
  function automatic logic [6:0] bcd_to_bin(input bcd_t tens, input bcd_t units);
    return (7'(tens) * 7'd10) + 7'(units);
  endfunction

endpackage

// File: rtl/sseg_digit_decode.sv
// Combinational decode of one 7-segment code into a BCD digit plus a legal flag.
// Both common renderings of 6 and 9 (with and without the extra tail segment) are accepted.
module sseg_digit_decode
  import scoreboard_pkg::*;
(
  input  sseg_t seg,
  output bcd_t  digit,
  output logic  legal
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (seg)
      SEG_0:          digit = 4'd0;
      SEG_1:          digit = 4'd1;
      SEG_2:          digit = 4'd2;
      SEG_3:          digit = 4'd3;
      SEG_4:          digit = 4'd4;
      SEG_5:          digit = 4'd5;
      SEG_6A, SEG_6B: digit = 4'd6;
      SEG_7:          digit = 4'd7;
      SEG_8:          digit = 4'd8;
      SEG_9A, SEG_9B: digit = 4'd9;
      default:        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_score_decoder.sv
// Recovers the displayed score from two 7-segment digits: glitch filter, legality check,
// and a latest-value valid/ready event output.
//
// Handshake: score_valid rises with score_bcd/score_bin loaded; all three hold until an edge
// with score_valid && score_ready, which clears score_valid. A new load needs score_valid low,
// so at least one idle cycle separates events; values stabilising meanwhile are not queued.
module sseg_score_decoder
  import scoreboard_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  sseg_t      sseg_hi,
  input  sseg_t      sseg_low,
  output logic [7:0] score_bcd,
  output logic [6:0] score_bin,
  output logic       score_valid,
  input  logic       score_ready,
  output logic       illegal,
  output logic [7:0] illegal_count,
  output dec_state_e dbg_state
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES - 1);

  logic [13:0] s;
  logic [7:0]  cnt;
  logic [7:0]  cnt_next;
  logic [7:0]  last_reported;
  logic        reported;
  dec_state_e  state;

  logic        changed;
  logic        stable_next;
  logic        pair_legal;
  logic        load;
  bcd_t        digit_hi;
  bcd_t        digit_low;
  logic        legal_hi;
  logic        legal_low;

  // Decode the registered sample; while the pair is unchanged it equals the live inputs.
  sseg_digit_decode u_dec_hi (
    .seg   (s[13:7]),
    .digit (digit_hi),
    .legal (legal_hi)
  );

  sseg_digit_decode u_dec_low (
    .seg   (s[6:0]),
    .digit (digit_low),
    .legal (legal_low)
  );

  always_comb begin
    changed  = ({sseg_hi, sseg_low} != s);
    cnt_next = 8'd0;
    if (!changed) begin
      cnt_next = (cnt == STABLE_MAX) ? cnt : cnt + 8'd1;
    end
    // Stability is judged on the value being written this edge, so the state and the
    // event both move on the edge that the counter reaches its ceiling.
    stable_next = !changed && (cnt_next == STABLE_MAX);
    pair_legal  = legal_hi && legal_low;
    load        = stable_next && pair_legal && !score_valid &&
                  (!reported || ({digit_hi, digit_low} != last_reported));
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      s             <= '0;
      cnt           <= '0;
      state         <= SETTLE;
      score_bcd     <= '0;
      score_bin     <= '0;
      score_valid   <= 1'b0;
      illegal_count <= '0;
      last_reported <= '0;
      reported      <= 1'b0;
    end else begin
      s   <= {sseg_hi, sseg_low};
      cnt <= cnt_next;

      if (changed) begin
        state <= SETTLE;
      end else if (state == SETTLE && stable_next) begin
        if (pair_legal) begin
          state <= STABLE_OK;
        end else begin
          state <= STABLE_BAD;
          if (illegal_count != 8'hFF) illegal_count <= illegal_count + 8'd1;
        end
      end

      if (load) begin
        score_bcd     <= {digit_hi, digit_low};
        score_bin     <= bcd_to_bin(digit_hi, digit_low);
        score_valid   <= 1'b1;
        last_reported <= {digit_hi, digit_low};
        reported      <= 1'b1;
      end else if (score_valid && score_ready) begin
        score_valid <= 1'b0;
      end
    end
  end

  assign illegal   = (state == STABLE_BAD);
  assign dbg_state = state;

endmodule
